fetch_unit: RTL and testbench

Instruction fetch sequencer driving the CPU's 16-bit program counter from the consuming side. It reads the current PC, issues a read to synchronous instruction memory, holds the returned instruction for decode with a valid/ready handshake, and computes the next PC. It drives the program counter's load port for both sequential advance (PC+1) and branch redirects.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the fetch sequencer and its neighbours.
//   ADDR_W / INSTR_W : program-counter and instruction widths
//   RESET_PC         : PC value after reset
//   fetch_state_e    : fetch sequencer state encoding (also visible on the
//                      fetch unit's debug port)
//   pc_incr()        : sequential PC advance, wraps modulo 2^ADDR_W
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned INSTR_W = 16;

   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      FS_ISSUE = 2'd0,
      FS_WAIT  = 2'd1,
      FS_HOLD  = 2'd2
   } fetch_state_e;

   // 0xFFFF + 1 wraps to 0x0000 because the result is ADDR_W bits wide.
   function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage : cpu_pkg

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch sequencer. Reads the current PC, issues a single-cycle
// read to synchronous instruction memory, holds the returned instruction for
// decode and drives the PC register's load port for sequential advance and
// branch redirects.
//
// Parameters
//   MEM_LATENCY    cycles from mem_rd to valid mem_rdata, legal range 1..4
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low
//   pc_cur         current PC (output of the PC register)
//   pc_next        value for the PC register to load (0 when pc_load is 0)
//   pc_load        PC load strobe, PC captures pc_next on the same edge
//   mem_addr       instruction memory address (0 when mem_rd is 0)
//   mem_rd         single-cycle read request
//   mem_rdata      read data, valid exactly MEM_LATENCY cycles after mem_rd
//   branch_taken   redirect request from execute
//   branch_target  redirect address
//   halt           suppresses new fetches (ISSUE state only)
//   ir_valid       ir_data / ir_pc hold a valid instruction
//   ir_ready       decode accepts the instruction when high with ir_valid
//   ir_data        fetched instruction
//   ir_pc          address the instruction was fetched from
//   fsm_state_dbg  current sequencer state, for observation only
//
// Decode handshake: an instruction transfers on a rising edge where
// ir_valid=1 and ir_ready=1 and branch_taken=0. Once ir_valid rises, ir_data
// and ir_pc stay stable until that transfer or until a branch discards the
// instruction. ir_valid never depends combinationally on ir_ready.
// ----------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_cur,
   output logic [ADDR_W-1:0]  pc_next,
   output logic               pc_load,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               halt,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic [INSTR_W-1:0] ir_data,
   output logic [ADDR_W-1:0]  ir_pc,
   output fetch_state_e       fsm_state_dbg
);

   // The counter is loaded on issue and the capture happens when it reaches
   // zero in WAIT, so WAIT lasts exactly MEM_LATENCY cycles.
   localparam logic [1:0] LAT_RELOAD = 2'(MEM_LATENCY - 1);

   fetch_state_e       state_q;
   logic [1:0]         cnt_q;
   logic               ir_valid_q;
   logic [INSTR_W-1:0] ir_data_q;
   logic [ADDR_W-1:0]  ir_pc_q;

   // -------------------------------------------------------------------------
   // Combinational memory / PC-load outputs. They are forced to zero while
   // reset is asserted so the PC register and memory see an idle fetch unit
   // immediately, independent of branch_taken or the clock.
   // -------------------------------------------------------------------------
   always_comb begin
      pc_load  = 1'b0;
      pc_next  = '0;
      mem_rd   = 1'b0;
      mem_addr = '0;
      if (reset) begin
         unique case (state_q)
            FS_ISSUE: begin
               // A redirect beats halt: the PC moves even when fetch is halted.
               if (branch_taken) begin
                  pc_load = 1'b1;
                  pc_next = branch_target;
               end else if (!halt) begin
                  mem_rd   = 1'b1;
                  mem_addr = pc_cur;
               end
            end
            FS_WAIT: begin
               if (branch_taken) begin
                  pc_load = 1'b1;
                  pc_next = branch_target;
               end
            end
            FS_HOLD: begin
               // Branch wins over acceptance; the held instruction is dropped.
               if (branch_taken) begin
                  pc_load = 1'b1;
                  pc_next = branch_target;
               end else if (ir_ready) begin
                  pc_load = 1'b1;
                  pc_next = pc_incr(pc_cur);
               end
            end
            default: begin
               pc_load  = 1'b0;
               pc_next  = '0;
               mem_rd   = 1'b0;
               mem_addr = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Sequencer state and registered instruction outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FS_ISSUE;
         cnt_q      <= 2'd0;
         ir_valid_q <= 1'b0;
         ir_data_q  <= '0;
         ir_pc_q    <= RESET_PC;
      end else begin
         unique case (state_q)
            FS_ISSUE: begin
               if (!branch_taken && !halt) begin
                  ir_pc_q <= pc_cur;
                  cnt_q   <= LAT_RELOAD;
                  state_q <= FS_WAIT;
               end
            end
            FS_WAIT: begin
               if (branch_taken) begin
                  // Fetch cancelled: whatever memory returns is never captured.
                  cnt_q   <= 2'd0;
                  state_q <= FS_ISSUE;
               end else if (cnt_q == 2'd0) begin
                  ir_data_q  <= mem_rdata;
                  ir_valid_q <= 1'b1;
                  state_q    <= FS_HOLD;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            FS_HOLD: begin
               if (branch_taken || ir_ready) begin
                  ir_valid_q <= 1'b0;
                  state_q    <= FS_ISSUE;
               end
            end
            default: begin
               ir_valid_q <= 1'b0;
               cnt_q      <= 2'd0;
               state_q    <= FS_ISSUE;
            end
         endcase
      end
   end

   assign ir_valid      = ir_valid_q;
   assign ir_data       = ir_data_q;
   assign ir_pc         = ir_pc_q;
   assign fsm_state_dbg = state_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import cpu_pkg::*;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = 16'h0000;
   logic        halt = 1'b0;
   logic        ir_ready = 1'b0;

   // Instance with MEM_LATENCY = 1
   logic [15:0] pc1_q, pc_next1, mem_addr1, mem_rdata1, ir_data1, ir_pc1;
   logic        pc_load1, mem_rd1, ir_valid1;
   fetch_state_e st1;

   // Instance with MEM_LATENCY = 3
   logic [15:0] pc3_q, pc_next3, mem_addr3, mem_rdata3, ir_data3, ir_pc3;
   logic        pc_load3, mem_rd3, ir_valid3;
   fetch_state_e st3;

   fetch_unit #(.MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .pc_cur(pc1_q), .pc_next(pc_next1), .pc_load(pc_load1),
      .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_rdata(mem_rdata1),
      .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
      .ir_valid(ir_valid1), .ir_ready(ir_ready), .ir_data(ir_data1), .ir_pc(ir_pc1),
      .fsm_state_dbg(st1)
   );

   fetch_unit #(.MEM_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .pc_cur(pc3_q), .pc_next(pc_next3), .pc_load(pc_load3),
      .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_rdata(mem_rdata3),
      .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
      .ir_valid(ir_valid3), .ir_ready(ir_ready), .ir_data(ir_data3), .ir_pc(ir_pc3),
      .fsm_state_dbg(st3)
   );

   // ---------------------------------------------------------------------------
   // Environment: PC registers and latency-accurate memories (word[n] = 0x1000+n)
   // ---------------------------------------------------------------------------
   function automatic logic [15:0] word_at(input logic [15:0] a);
      return 16'h1000 + a;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc1_q <= 16'h0000;
      else if (pc_load1) pc1_q <= pc_next1;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc3_q <= 16'h0000;
      else if (pc_load3) pc3_q <= pc_next3;
   end

   logic [3:0]  p1_v, p3_v;
   logic [15:0] p1_a [4];
   logic [15:0] p3_a [4];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p1_v <= '0;
         p3_v <= '0;
         for (int k = 0; k < 4; k++) begin
            p1_a[k] <= '0;
            p3_a[k] <= '0;
         end
      end else begin
         p1_v    <= {p1_v[2:0], mem_rd1};
         p3_v    <= {p3_v[2:0], mem_rd3};
         p1_a[0] <= mem_addr1;
         p3_a[0] <= mem_addr3;
         for (int k = 1; k < 4; k++) begin
            p1_a[k] <= p1_a[k-1];
            p3_a[k] <= p3_a[k-1];
         end
      end
   end

   // Data not belonging to a read slot is poison so a stray capture shows up.
   assign mem_rdata1 = p1_v[0] ? word_at(p1_a[0]) : 16'hDEAD;
   assign mem_rdata3 = p3_v[2] ? word_at(p3_a[2]) : 16'hDEAD;

   // ---------------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Per-cycle vector table for the MEM_LATENCY=1 instance
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        br;
      logic [15:0] tgt;
      logic        hlt;
      logic        rdy;
      logic [1:0]  e_st;
      logic        e_rd;
      logic [15:0] e_addr;
      logic        e_load;
      logic [15:0] e_next;
      logic        e_vld;
      logic [15:0] e_data;
      logic [15:0] e_pc;
   } vec_t;

   vec_t vec_q[$];

   localparam logic [1:0] I = 2'd0, W = 2'd1, H = 2'd2;

   task automatic add(input logic br, input logic [15:0] tgt, input logic hlt, input logic rdy,
                      input logic [1:0] st, input logic rd, input logic [15:0] addr,
                      input logic ld, input logic [15:0] nxt, input logic vld,
                      input logic [15:0] dat, input logic [15:0] ipc);
      vec_t v;
      v.br = br; v.tgt = tgt; v.hlt = hlt; v.rdy = rdy;
      v.e_st = st; v.e_rd = rd; v.e_addr = addr; v.e_load = ld; v.e_next = nxt;
      v.e_vld = vld; v.e_data = dat; v.e_pc = ipc;
      vec_q.push_back(v);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " state"},    16'(st1),      16'h0000);
      chk({tag, " mem_rd"},   16'(mem_rd1),  16'h0000);
      chk({tag, " mem_addr"}, mem_addr1,     16'h0000);
      chk({tag, " pc_load"},  16'(pc_load1), 16'h0000);
      chk({tag, " pc_next"},  pc_next1,      16'h0000);
      chk({tag, " ir_valid"}, 16'(ir_valid1), 16'h0000);
      chk({tag, " ir_data"},  ir_data1,      16'h0000);
      chk({tag, " ir_pc"},    ir_pc1,        16'h0000);
   endtask

   initial begin
      //   br  tgt      hlt rdy  st rd addr     ld next     vld data     ir_pc
      // straight-line fetch, one instruction every 3 cycles
      add(0, 16'h0000, 0, 1,   I, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000); // c0
      add(0, 16'h0000, 0, 1,   W, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000); // c1
      add(0, 16'h0000, 0, 1,   H, 0, 16'h0000, 1, 16'h0001, 1, 16'h1000, 16'h0000); // c2
      add(0, 16'h0000, 0, 1,   I, 1, 16'h0001, 0, 16'h0000, 0, 16'h1000, 16'h0000); // c3
      add(0, 16'h0000, 0, 1,   W, 0, 16'h0000, 0, 16'h0000, 0, 16'h1000, 16'h0001); // c4
      add(0, 16'h0000, 0, 1,   H, 0, 16'h0000, 1, 16'h0002, 1, 16'h1001, 16'h0001); // c5
      add(0, 16'h0000, 0, 1,   I, 1, 16'h0002, 0, 16'h0000, 0, 16'h1001, 16'h0001); // c6
      add(0, 16'h0000, 0, 1,   W, 0, 16'h0000, 0, 16'h0000, 0, 16'h1001, 16'h0002); // c7
      // decode stalls 5 cycles in HOLD, then accepts
      for (int k = 0; k < 5; k++)
         add(0, 16'h0000, 0, 0, H, 0, 16'h0000, 0, 16'h0000, 1, 16'h1002, 16'h0002); // c8..c12
      add(0, 16'h0000, 0, 1,   H, 0, 16'h0000, 1, 16'h0003, 1, 16'h1002, 16'h0002); // c13
      add(0, 16'h0000, 0, 1,   I, 1, 16'h0003, 0, 16'h0000, 0, 16'h1002, 16'h0002); // c14
      // branch in WAIT: no capture of word[3]
      add(1, 16'h0040, 0, 1,   W, 0, 16'h0000, 1, 16'h0040, 0, 16'h1002, 16'h0003); // c15
      add(0, 16'h0000, 0, 1,   I, 1, 16'h0040, 0, 16'h0000, 0, 16'h1002, 16'h0003); // c16
      add(0, 16'h0000, 0, 1,   W, 0, 16'h0000, 0, 16'h0000, 0, 16'h1002, 16'h0040); // c17
      // branch together with ir_ready in HOLD: branch wins
      add(1, 16'h0100, 0, 1,   H, 0, 16'h0000, 1, 16'h0100, 1, 16'h1040, 16'h0040); // c18
      add(0, 16'h0000, 0, 1,   I, 1, 16'h0100, 0, 16'h0000, 0, 16'h1040, 16'h0040); // c19
      add(0, 16'h0000, 0, 1,   W, 0, 16'h0000, 0, 16'h0000, 0, 16'h1040, 16'h0100); // c20
      // branch in HOLD without ready: instruction discarded
      add(1, 16'hFFFF, 0, 0,   H, 0, 16'h0000, 1, 16'hFFFF, 1, 16'h1100, 16'h0100); // c21
      // halt 4 cycles in ISSUE, last one with a simultaneous branch
      for (int k = 0; k < 3; k++)
         add(0, 16'h0000, 1, 1, I, 0, 16'h0000, 0, 16'h0000, 0, 16'h1100, 16'h0100); // c22..c24
      add(1, 16'hFFFF, 1, 1,   I, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h1100, 16'h0100); // c25
      // PC wrap: fetch from 0xFFFF, accept -> 0x0000
      add(0, 16'h0000, 0, 1,   I, 1, 16'hFFFF, 0, 16'h0000, 0, 16'h1100, 16'h0100); // c26
      add(0, 16'h0000, 0, 1,   W, 0, 16'h0000, 0, 16'h0000, 0, 16'h1100, 16'hFFFF); // c27
      add(0, 16'h0000, 0, 1,   H, 0, 16'h0000, 1, 16'h0000, 1, 16'h0FFF, 16'hFFFF); // c28
      add(0, 16'h0000, 0, 1,   I, 1, 16'h0000, 0, 16'h0000, 0, 16'h0FFF, 16'hFFFF); // c29
      add(0, 16'h0000, 0, 1,   W, 0, 16'h0000, 0, 16'h0000, 0, 16'h0FFF, 16'h0000); // c30
      // halt has no effect in HOLD
      add(0, 16'h0000, 1, 0,   H, 0, 16'h0000, 0, 16'h0000, 1, 16'h1000, 16'h0000); // c31
      add(0, 16'h0000, 0, 0,   H, 0, 16'h0000, 0, 16'h0000, 1, 16'h1000, 16'h0000); // c32
      add(0, 16'h0000, 0, 1,   H, 0, 16'h0000, 1, 16'h0001, 1, 16'h1000, 16'h0000); // c33
      add(0, 16'h0000, 0, 1,   I, 1, 16'h0001, 0, 16'h0000, 0, 16'h1000, 16'h0000); // c34
      add(0, 16'h0000, 0, 1,   W, 0, 16'h0000, 0, 16'h0000, 0, 16'h1000, 16'h0001); // c35

      // ------------------------------------------------------------------------
      // Reset state
      // ------------------------------------------------------------------------
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      // ------------------------------------------------------------------------
      // Vector table, one entry per cycle starting with cycle 0 after release
      // ------------------------------------------------------------------------
      foreach (vec_q[i]) begin
         string c;
         c = $sformatf("c%0d", i);
         branch_taken  = vec_q[i].br;
         branch_target = vec_q[i].tgt;
         halt          = vec_q[i].hlt;
         ir_ready      = vec_q[i].rdy;
         #1;
         chk({c, " state"},    16'(st1),       16'(vec_q[i].e_st));
         chk({c, " mem_rd"},   16'(mem_rd1),   16'(vec_q[i].e_rd));
         chk({c, " mem_addr"}, mem_addr1,      vec_q[i].e_addr);
         chk({c, " pc_load"},  16'(pc_load1),  16'(vec_q[i].e_load));
         chk({c, " pc_next"},  pc_next1,       vec_q[i].e_next);
         chk({c, " ir_valid"}, 16'(ir_valid1), 16'(vec_q[i].e_vld));
         chk({c, " ir_data"},  ir_data1,       vec_q[i].e_data);
         chk({c, " ir_pc"},    ir_pc1,         vec_q[i].e_pc);
         if (i != vec_q.size() - 1) @(negedge clk);
      end

      // ------------------------------------------------------------------------
      // Reset asserted mid-WAIT (with a branch pending): outputs zero at once
      // ------------------------------------------------------------------------
      #1;
      branch_taken  = 1'b1;
      branch_target = 16'h1234;
      reset         = 1'b0;
      #1;
      check_all_zero("rst_in_wait");
      branch_taken  = 1'b0;
      branch_target = 16'h0000;
      repeat (2) @(negedge clk);
      reset    = 1'b1;
      ir_ready = 1'b1;
      halt     = 1'b0;

      // ------------------------------------------------------------------------
      // Latency comparison: ir_valid at 2,5,8,11 (latency 1) and 4,9 (latency 3)
      // ------------------------------------------------------------------------
      for (int n = 0; n < 12; n++) begin
         #1;
         chk($sformatf("lat1 ir_valid n%0d", n), 16'(ir_valid1),
             16'((n == 2) || (n == 5) || (n == 8) || (n == 11)));
         chk($sformatf("lat3 ir_valid n%0d", n), 16'(ir_valid3),
             16'((n == 4) || (n == 9)));
         if (n == 4) begin
            chk("lat3 first ir_data", ir_data3, 16'h1000);
            chk("lat3 first ir_pc",   ir_pc3,   16'h0000);
         end
         if (n == 8) begin
            chk("lat1 third ir_data", ir_data1, 16'h1002);
            chk("lat1 third ir_pc",   ir_pc1,   16'h0002);
         end
         if (n == 9) begin
            chk("lat3 second ir_data", ir_data3, 16'h1001);
            chk("lat3 second ir_pc",   ir_pc3,   16'h0001);
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fetch_unit
